// File: rtl/fpmul_arbiter.sv
// fpmul_arbiter: shares one external FP multiplier between two requesters.
// Each requester hands over its operands (valid/ack), and later collects
// its product (rdy/taken, four-phase). One operation is in flight at a time.
module fpmul_arbiter #(
  parameter int RR_EN = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  output logic        req0_ack,
  output logic [31:0] req0_result,
  output logic        req0_rdy,
  input  logic        req0_taken,
  input  logic        req1_valid,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  output logic        req1_ack,
  output logic [31:0] req1_result,
  output logic        req1_rdy,
  input  logic        req1_taken,
  output logic [31:0] core_x,
  output logic [31:0] core_y,
  output logic        core_start,
  input  logic [31:0] core_result,
  input  logic        core_done,
  output logic        busy,
  output logic        grant_id
);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, STORE} state_t;

  // Last WAIT_BUSY count before the strobe is considered lost (8 cycles).
  localparam logic [2:0] RETRY_LAST = 3'd7;

  state_t      state_q, state_d;
  logic        grant_q, grant_d;
  logic [31:0] x_q, x_d, y_q, y_d;
  logic [1:0]  ack_q, ack_d;
  logic [1:0]  rdy_q, rdy_d;
  logic [31:0] res0_q, res0_d, res1_q, res1_d;
  logic [2:0]  cnt_q, cnt_d;

  logic [1:0]  valid, taken, elig;
  logic        pick;

  assign valid = {req1_valid, req0_valid};
  assign taken = {req1_taken, req0_taken};

  // A requester competes only when its operands are new: not yet captured,
  // no result outstanding, and its previous completion handshake finished.
  assign elig = valid & ~ack_q & ~rdy_q & ~taken;

  // Arbitration: on contention, round-robin favours the one not served last;
  // fixed priority always favours req0.
  always_comb begin
    pick = 1'b0;
    if (elig == 2'b11) pick = (RR_EN != 0) ? ~grant_q : 1'b0;
    else               pick = elig[1];
  end

  // Next-state and datapath update for the single operation in flight.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    x_d     = x_q;
    y_d     = y_q;
    cnt_d   = cnt_q;
    res0_d  = res0_q;
    res1_d  = res1_q;
    // ack drops once the requester lets go of valid; rdy drops on taken.
    ack_d   = ack_q & valid;
    rdy_d   = rdy_q & ~taken;
    unique case (state_q)
      IDLE: begin
        // Only grant when the multiplier reports idle.
        if (core_done && (elig != 2'b00)) begin
          state_d     = ISSUE;
          grant_d     = pick;
          x_d         = pick ? req1_a : req0_a;
          y_d         = pick ? req1_b : req0_b;
          ack_d[pick] = 1'b1;
        end
      end
      ISSUE: begin
        state_d = WAIT_BUSY;
        cnt_d   = '0;
      end
      WAIT_BUSY: begin
        // Core going low means it accepted the strobe; staying high for
        // 8 cycles means it missed it, so strobe again.
        if (!core_done) begin
          state_d = WAIT_DONE;
          cnt_d   = '0;
        end else if (cnt_q == RETRY_LAST) begin
          state_d = ISSUE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      WAIT_DONE: begin
        if (core_done) state_d = STORE;
      end
      STORE: begin
        state_d = IDLE;
        if (grant_q) begin
          res1_d   = core_result;
          rdy_d[1] = 1'b1;
        end else begin
          res0_d   = core_result;
          rdy_d[0] = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset leaves grant_q=1 so req0 wins the first contention.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      grant_q <= 1'b1;
      x_q     <= '0;
      y_q     <= '0;
      ack_q   <= '0;
      rdy_q   <= '0;
      res0_q  <= '0;
      res1_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      x_q     <= x_d;
      y_q     <= y_d;
      ack_q   <= ack_d;
      rdy_q   <= rdy_d;
      res0_q  <= res0_d;
      res1_q  <= res1_d;
      cnt_q   <= cnt_d;
    end
  end

  assign core_x      = x_q;
  assign core_y      = y_q;
  assign core_start  = (state_q == ISSUE);
  assign busy        = (state_q != IDLE);
  assign grant_id    = grant_q;
  assign req0_ack    = ack_q[0];
  assign req1_ack    = ack_q[1];
  assign req0_rdy    = rdy_q[0];
  assign req1_rdy    = rdy_q[1];
  assign req0_result = res0_q;
  assign req1_result = res1_q;

endmodule

// File: tb/tb_fpmul_arbiter.sv
// Bench for fpmul_arbiter: two instances (round-robin and fixed priority)
// run side by side, each with its own multiplier model and requesters.
module tb_fpmul_arbiter;
  localparam int NTX = 15;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        valid [2][2];
  logic        taken [2][2];
  logic [31:0] opa   [2][2];
  logic [31:0] opb   [2][2];
  logic        cdone [2];
  logic [31:0] cres  [2];
  wire         ack   [2][2];
  wire         rdy   [2][2];
  wire  [31:0] res   [2][2];
  wire  [31:0] cx    [2];
  wire  [31:0] cy    [2];
  wire         cstart[2];
  wire         busy  [2];
  wire         gid   [2];

  int n_chk = 0, n_pass = 0;
  int starts [2] = '{0, 0};
  bit ign_once [2] = '{1'b0, 1'b0};
  int ign_pct = 0;
  int lat_dir = 20;
  bit go_rand = 1'b0;
  int agents_done = 0;
  logic [31:0] optab [8] = '{32'h3F000000, 32'h3F800000, 32'h3FC00000, 32'h40000000,
                             32'h40400000, 32'h40800000, 32'h3F400000, 32'hC0000000};

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, act, exp);
  endtask

  // Single-precision <-> real for exactly representable normal values.
  function automatic real f2r(input logic [31:0] f);
    real r;
    int  e;
    r = 1.0 + real'(f[22:0]) / 8388608.0;
    e = int'(f[30:23]) - 127;
    while (e > 0) begin r = r * 2.0; e--; end
    while (e < 0) begin r = r / 2.0; e++; end
    return f[31] ? -r : r;
  endfunction

  function automatic logic [31:0] r2f(input real v);
    real  m;
    int   e;
    logic s;
    s = (v < 0.0);
    m = s ? -v : v;
    e = 127;
    while (m >= 2.0) begin m = m / 2.0; e++; end
    while (m < 1.0)  begin m = m * 2.0; e--; end
    return {s, 8'(e), 23'($rtoi((m - 1.0) * 8388608.0))};
  endfunction

  function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
    return r2f(f2r(a) * f2r(b));
  endfunction

  for (genvar d = 0; d < 2; d++) begin : g_dut
    fpmul_arbiter #(.RR_EN(d == 0 ? 1 : 0)) u_dut (
      .clk(clk), .rst(rst),
      .req0_valid(valid[d][0]), .req0_a(opa[d][0]), .req0_b(opb[d][0]),
      .req0_ack(ack[d][0]), .req0_result(res[d][0]), .req0_rdy(rdy[d][0]),
      .req0_taken(taken[d][0]),
      .req1_valid(valid[d][1]), .req1_a(opa[d][1]), .req1_b(opb[d][1]),
      .req1_ack(ack[d][1]), .req1_result(res[d][1]), .req1_rdy(rdy[d][1]),
      .req1_taken(taken[d][1]),
      .core_x(cx[d]), .core_y(cy[d]), .core_start(cstart[d]),
      .core_result(cres[d]), .core_done(cdone[d]),
      .busy(busy[d]), .grant_id(gid[d]));

    // Multiplier model: done drops while computing; may ignore a strobe,
    // after which the next strobe must come exactly 9 cycles later.
    initial begin : core
      int cnt, since;
      logic [31:0] p;
      cnt = 0; since = -1; p = '0;
      cdone[d] = 1'b1;
      cres[d]  = '0;
      forever begin
        @(negedge clk);
        if (since >= 0) since++;
        if (!rst) since = -1;
        if (cnt > 0) begin
          cnt--;
          if (cnt == 0) begin cdone[d] = 1'b1; cres[d] = p; end
        end else if (cstart[d]) begin
          starts[d]++;
          if (since >= 0) chk("retry_gap", 32'(since), 32'd9);
          if (ign_once[d] || (ign_pct != 0 && $urandom_range(99) < ign_pct)) begin
            ign_once[d] = 1'b0;
            since = 0;
          end else begin
            since = -1;
            p = fmul(cx[d], cy[d]);
            cnt = (lat_dir > 0) ? lat_dir : int'($urandom_range(6, 2));
            cdone[d] = 1'b0;
          end
        end
      end
    end

    // Grant monitor: legality, arbitration order and captured operands.
    initial begin : mon
      logic e0, e1, pa0, pa1, pb, pd, pr, g0, g1;
      int last, exp_id, got;
      last = 1;
      forever begin
        @(negedge clk); #1;
        pr = rst; pb = busy[d]; pd = cdone[d];
        pa0 = ack[d][0]; pa1 = ack[d][1];
        e0 = valid[d][0] & ~ack[d][0] & ~rdy[d][0] & ~taken[d][0];
        e1 = valid[d][1] & ~ack[d][1] & ~rdy[d][1] & ~taken[d][1];
        @(posedge clk); #1;
        g0 = ack[d][0] & ~pa0;
        g1 = ack[d][1] & ~pa1;
        if (!pr) begin
          last = 1;
        end else if (g0 | g1) begin
          got = g1 ? 1 : 0;
          if (e0 && e1) exp_id = (d == 0) ? 1 - last : 0;
          else          exp_id = e1 ? 1 : 0;
          chk("grant_legal", 32'(!pb && pd && !(g0 && g1) && (g1 ? e1 : e0)), 32'd1);
          chk("grant_who", 32'(got), 32'(exp_id));
          chk("grant_id", 32'(gid[d]), 32'(got));
          chk("core_x", cx[d], opa[d][got]);
          chk("core_y", cy[d], opb[d][got]);
          last = got;
        end else if (!pb && pd && (e0 || e1)) begin
          chk("grant_missing", 32'(g0 | g1), 32'd1);
        end
      end
    end

    // Random requesters with a reference product per transaction.
    for (genvar n = 0; n < 2; n++) begin : g_req
      initial begin : agent
        logic [31:0] ea, eb, er;
        int w, hold;
        wait (go_rand);
        @(negedge clk);
        for (int k = 0; k < NTX; k++) begin
          repeat ($urandom_range(1)) @(negedge clk);
          ea = optab[$urandom_range(7)];
          eb = optab[$urandom_range(7)];
          er = fmul(ea, eb);
          opa[d][n] = ea; opb[d][n] = eb; valid[d][n] = 1'b1;
          w = 0;
          while (!ack[d][n] && w < 400) begin @(posedge clk); #1; w++; end
          chk("rand_ack", 32'(ack[d][n]), 32'd1);
          repeat ($urandom_range(2)) @(negedge clk);
          @(negedge clk);
          valid[d][n] = 1'b0;
          w = 0;
          while (!rdy[d][n] && w < 400) begin @(posedge clk); #1; w++; end
          chk("rand_rdy", 32'(rdy[d][n]), 32'd1);
          chk("rand_result", res[d][n], er);
          hold = (d == 0 && n == 1 && k == 0) ? 50 : int'($urandom_range(3));
          for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk("hold_rdy", 32'(rdy[d][n]), 32'd1);
            chk("hold_result", res[d][n], er);
          end
          @(negedge clk);
          taken[d][n] = 1'b1;
          @(posedge clk); #1;
          chk("rand_rdy_clear", 32'(rdy[d][n]), 32'd0);
          chk("rand_ack_clear", 32'(ack[d][n]), 32'd0);
          @(negedge clk);
          taken[d][n] = 1'b0;
        end
        agents_done++;
      end
    end
  end

  task automatic reset_state(input string tag);
    for (int d = 0; d < 2; d++) begin
      chk({tag, "_ctrl"}, 32'({ack[d][0], ack[d][1], rdy[d][0], rdy[d][1],
                               cstart[d], busy[d], gid[d]}), 32'd1);
      chk({tag, "_data"}, cx[d] | cy[d] | res[d][0] | res[d][1], 32'd0);
    end
  endtask

  task automatic set_req(input int n, input logic [31:0] a, input logic [31:0] b);
    for (int d = 0; d < 2; d++) begin
      opa[d][n] = a; opb[d][n] = b; valid[d][n] = 1'b1;
    end
  endtask

  task automatic drop(input int n);
    @(negedge clk);
    for (int d = 0; d < 2; d++) valid[d][n] = 1'b0;
  endtask

  task automatic wait_sig(input bit sel_rdy, input int n, input string tag);
    int w;
    bit ok;
    w = 0; ok = 1'b0;
    while (!ok && w < 200) begin
      @(posedge clk); #1; w++;
      ok = sel_rdy ? (rdy[0][n] && rdy[1][n]) : (ack[0][n] && ack[1][n]);
    end
    chk(tag, 32'(ok), 32'd1);
  endtask

  task automatic chk_res(input int n, input logic [31:0] exp, input string tag);
    for (int d = 0; d < 2; d++) chk(tag, res[d][n], exp);
  endtask

  task automatic take(input int n);
    @(negedge clk);
    for (int d = 0; d < 2; d++) taken[d][n] = 1'b1;
    @(posedge clk); #1;
    for (int d = 0; d < 2; d++) chk("take_clear", 32'(rdy[d][n]), 32'd0);
    @(negedge clk);
    for (int d = 0; d < 2; d++) taken[d][n] = 1'b0;
  endtask

  task automatic pulse_reset();
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    @(negedge clk); rst = 1'b1;
  endtask

  initial begin
    int s0, w;
    rst = 1'b0;
    for (int d = 0; d < 2; d++)
      for (int n = 0; n < 2; n++) begin
        valid[d][n] = 1'b0; taken[d][n] = 1'b0; opa[d][n] = '0; opb[d][n] = '0;
      end
    repeat (3) @(posedge clk);
    #1;
    reset_state("reset");
    @(negedge clk); rst = 1'b1;

    // Single request, 20-cycle core.
    @(negedge clk);
    s0 = starts[0];
    set_req(0, 32'h3FC00000, 32'h40000000);
    wait_sig(1'b0, 0, "single_ack");
    drop(0);
    wait_sig(1'b1, 0, "single_rdy");
    chk_res(0, 32'h40400000, "single_result");
    chk("single_starts", 32'(starts[0] - s0), 32'd1);
    for (int d = 0; d < 2; d++)
      chk("single_req1_idle", 32'({ack[d][1], rdy[d][1]}) | res[d][1], 32'd0);
    take(0);

    // Simultaneous requests right after reset: req0 first, then req1.
    pulse_reset();
    @(negedge clk);
    set_req(0, 32'h40400000, 32'h40400000);
    set_req(1, 32'h40800000, 32'h3F000000);
    wait_sig(1'b0, 0, "both_ack0");
    for (int d = 0; d < 2; d++) chk("both_req1_waits", 32'(ack[d][1]), 32'd0);
    drop(0);
    wait_sig(1'b1, 0, "both_rdy0");
    chk_res(0, 32'h41100000, "both_result0");
    take(0);
    wait_sig(1'b0, 1, "both_ack1");
    drop(1);
    wait_sig(1'b1, 1, "both_rdy1");
    chk_res(1, 32'h40000000, "both_result1");
    for (int d = 0; d < 2; d++) chk("both_grant_id", 32'(gid[d]), 32'd1);
    take(1);

    // Core ignores the first strobe.
    @(negedge clk);
    s0 = starts[0];
    ign_once[0] = 1'b1; ign_once[1] = 1'b1;
    set_req(0, 32'h40000000, 32'h40800000);
    wait_sig(1'b0, 0, "retry_ack");
    drop(0);
    wait_sig(1'b1, 0, "retry_rdy");
    chk_res(0, 32'h41000000, "retry_result");
    chk("retry_starts", 32'(starts[0] - s0), 32'd2);
    take(0);

    // Reset while waiting for the core; no grant until the core is idle.
    @(negedge clk);
    set_req(0, 32'h3F800000, 32'h3FC00000);
    wait_sig(1'b0, 0, "rst_mid_ack");
    drop(0);
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) chk("rst_mid_waiting", 32'({busy[d], cdone[d]}), 32'd2);
    @(negedge clk);
    rst = 1'b0;
    set_req(1, 32'h40400000, 32'h3F400000);
    @(posedge clk); #1;
    reset_state("rst_mid");
    @(negedge clk); rst = 1'b1;
    repeat (4) begin
      @(posedge clk); #1;
      for (int d = 0; d < 2; d++) chk("rst_mid_nogrant", 32'(ack[d][1]), 32'd0);
    end
    wait_sig(1'b0, 1, "rst_mid_ack1");
    drop(1);
    wait_sig(1'b1, 1, "rst_mid_rdy1");
    chk_res(1, 32'h40100000, "rst_mid_result1");
    for (int d = 0; d < 2; d++) chk("rst_mid_req0_dropped", 32'(rdy[d][0]), 32'd0);
    take(1);

    // Randomized contention with short cores and occasional lost strobes.
    lat_dir = 0;
    ign_pct = 20;
    go_rand = 1'b1;
    w = 0;
    while (agents_done < 4 && w < 60000) begin @(posedge clk); w++; end
    chk("agents_done", 32'(agents_done), 32'd4);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/fpmul_arbiter.md
FPMUL_ARBITER -- requirements
Module: fpmul_arbiter

Interface
REQ-001 SHALL have parameter RR_EN, default 1, meaning 1 = round-robin arbitration and 0 = fixed priority with req0 highest.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-low.
REQ-004 SHALL have ports req0_valid / req1_valid  input  1  request from requester N; operands are stable while high.
REQ-005 SHALL have ports req0_a, req0_b / req1_a, req1_b  input  32  IEEE-754 single-precision operands.
REQ-006 SHALL have ports req0_ack / req1_ack  output  1  operands of requester N have been captured.
REQ-007 SHALL have ports req0_result / req1_result  output  32  registered product for requester N.
REQ-008 SHALL have ports req0_rdy / req1_rdy  output  1  result of requester N is valid.
REQ-009 SHALL have ports req0_taken / req1_taken  input  1  requester N has consumed its result.
REQ-010 SHALL have ports core_x, core_y  output  32  registered operands to the shared FP multiplier.
REQ-011 SHALL have port core_start  output  1  start strobe to the multiplier.
REQ-012 SHALL have port core_result  input  32  multiplier product.
REQ-013 SHALL have port core_done  input  1  multiplier status: high when idle, low while computing.
REQ-014 SHALL have ports busy  output  1 (high when FSM is not IDLE) and grant_id  output  1 (requester currently or last served).

Function
REQ-015 SHALL implement FSM states IDLE, ISSUE, WAIT_BUSY, WAIT_DONE and STORE.
REQ-016 SHALL treat requester N as eligible when reqN_valid=1, reqN_ack=0, reqN_rdy=0 and reqN_taken=0.
REQ-017 In IDLE with at least one eligible requester and core_done=1, SHALL, at the same edge:
 - set grant_id;
 - load core_x/core_y from that requester's a/b;
 - set reqN_ack=1;
 - go to ISSUE.
REQ-018 In IDLE with core_done=0, SHALL grant nothing and remain in IDLE.
REQ-019 When both requesters are eligible: with RR_EN=1, SHALL grant the requester that is not grant_id; with RR_EN=0, SHALL grant req0.
REQ-020 SHALL hold reqN_ack high until reqN_valid is sampled low, then clear it on the following edge.
REQ-021 SHALL drive core_start=1 for exactly one cycle (state ISSUE), then go to WAIT_BUSY.
REQ-022 In WAIT_BUSY, SHALL go to WAIT_DONE when core_done=0.
REQ-023 In WAIT_BUSY, SHALL count cycles and, if core_done stays high for 8 cycles, return to ISSUE and re-strobe core_start (retry is unlimited).
REQ-024 In WAIT_DONE, SHALL go to STORE when core_done=1.
REQ-025 In STORE, SHALL load reqN_result from core_result, set reqN_rdy=1 for N=grant_id, and return to IDLE.
REQ-026 SHALL hold reqN_rdy and reqN_result stable until reqN_taken=1, then clear reqN_rdy on the next edge.
REQ-027 SHALL keep requester N ineligible while reqN_taken remains high (four-phase completion).
REQ-028 SHALL leave a pending result on one requester unaffected by service to the other.
REQ-029 SHALL keep core_x/core_y constant from grant until the next grant.
REQ-030 SHALL have best-case latency from the reqN_valid sample to reqN_rdy=1 of 4 cycles plus the core computation time.
REQ-031 SHALL ignore a request that drops before grant.
REQ-032 SHALL NOT modify a result or ack when a request drops after grant; the operation completes.

Reset
REQ-033 While rst=0 at a rising edge, SHALL force the following, overriding every other condition including mid-operation states:
 - FSM to IDLE;
 - all reqN_ack, reqN_rdy, core_start and busy to 0;
 - core_x, core_y and reqN_result to 0;
 - grant_id to 1, so req0 wins the first contention;
 - WAIT_BUSY counter to 0.
REQ-034 SHALL NOT reset the multiplier; after reset, SHALL wait in IDLE until core_done=1 before granting.

Verification
REQ-035 Single request: req0 a=0x3FC00000, b=0x40000000, core model 20 cycles -> one core_start pulse; req0_rdy with req0_result=0x40400000; req1 outputs untouched.
REQ-036 Simultaneous requests, RR_EN=1: req0 (0x40400000 x 0x40400000) and req1 (0x40800000 x 0x3F000000) -> req0 served first (0x41100000), then req1 (0x40000000); grant_id ends at 1.
REQ-037 Back-to-back contention, RR_EN=1, both requesters re-request immediately after taken -> grants alternate 0,1,0,1; with RR_EN=0 -> req0 always wins.
REQ-038 Core ignores the first strobe (core_done held high for 8 cycles) -> core_start re-pulses; the result is still delivered correctly.
REQ-039 rst=0 asserted during WAIT_DONE -> next cycle all outputs are 0, grant_id=1 and the FSM is in IDLE; no grant occurs until core_done=1.
REQ-040 Result held: req1_taken kept 0 for 50 cycles -> req1_rdy and req1_result stay stable, req0 continues to be served, and req1 is not re-granted.
